// File: rtl/dmem_dump_streamer.sv
// dmem_dump_streamer: walks a window of data memory and streams each word out little-endian as bytes over valid/ready.
module dmem_dump_streamer #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = BYTES > 1 ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_rem;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              w_hs, w_last, w_final;

    assign w_hs    = r_state == S_SEND && tx_ready;
    assign w_last  = r_idx == IDX_W'(BYTES - 1);
    assign w_final = r_rem == (ADDR_W + 1)'(1);

    always_ff @(posedge clk or negedge areset)
        if (!areset) r_state <= S_IDLE;
        else         r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? (word_count == '0 ? S_DONE : S_FETCH) : S_IDLE;
            S_FETCH: w_next = S_SEND;
            S_SEND:  w_next = w_hs && w_last ? (w_final ? S_DONE : S_FETCH) : S_SEND;
            default: w_next = S_IDLE;
        endcase
    end

    // Address increment wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            r_addr  <= '0;
            r_rem   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else if (r_state == S_IDLE && start && word_count != '0) begin
            r_addr <= base_addr;
            r_rem  <= word_count;
        end else if (r_state == S_FETCH) begin
            r_shift <= mem_rdata;
            r_idx   <= '0;
        end else if (w_hs && !w_last) begin
            r_shift <= r_shift >> 8;
            r_idx   <= r_idx + 1'b1;
        end else if (w_hs) begin
            r_rem  <= r_rem - 1'b1;
            r_addr <= w_final ? r_addr : r_addr + 1'b1;
        end
    end

    assign mem_addr = r_addr;
    assign tx_data  = r_shift[7:0];
    assign tx_valid = r_state == S_SEND;
    assign busy     = r_state == S_FETCH || r_state == S_SEND;
    assign done     = r_state == S_DONE;
endmodule

// File: tb/tb_dmem_dump_streamer.sv
// tb_dmem_dump_streamer: table-driven dump vectors plus hand-written reset-mid-dump sequence.
module tb_dmem_dump_streamer;
    logic        clk = 0, areset = 0, start = 0, tx_ready = 0;
    logic [5:0]  base_addr = 0;
    logic [6:0]  word_count = 0;
    logic [5:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid, busy, done;
    logic [31:0] mem [64];
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];

    dmem_dump_streamer dut (
        .clk(clk), .areset(areset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [5:0]   base;
        logic [6:0]   cnt;
        int           stall;
        int           pulse;
        int           nb;
        int           done_c;
        logic [127:0] exp;
        logic [23:0]  addrs;
    } vec_t;

    vec_t        v[5];
    logic [7:0]  got[$];
    logic [5:0]  got_addr[$];
    int          done_c, done_n, busy_after;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle c=1 is the cycle right after the edge that samples start (FETCH of word 0).
    task automatic run_dump(input logic [5:0] b, input logic [6:0] n, input int stall, input int pulse);
        int         st = 0;
        logic [7:0] held = 0;
        got.delete();
        got_addr.delete();
        done_c = -1;
        done_n = 0;
        busy_after = 0;
        base_addr = b;
        word_count = n;
        start = 1;
        tx_ready = 0;
        @(posedge clk); #1;
        for (int c = 1; c <= 80; c++) begin
            start = (c == pulse);
            tx_ready = tx_valid && st >= stall;
            if (tx_valid) begin
                if (st > 0) chk("stall_hold", 128'(tx_data), 128'(held));
                held = tx_data;
                if (tx_ready) begin
                    if (got.size() % 4 == 0) got_addr.push_back(mem_addr);
                    got.push_back(tx_data);
                    st = 0;
                end else st++;
            end
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            if (done_c >= 0 && c > done_c && busy) busy_after++;
            @(posedge clk); #1;
        end
        start = 0;
        tx_ready = 0;
    endtask

    initial begin
        int quiet;
        v[0] = '{6'd0,  7'd3, 0, 0, 12, 16, 128'h00000000_00000001_AABBCCDD_11223344, {6'd2, 6'd1, 6'd0}};
        v[1] = '{6'd62, 7'd4, 0, 0, 16, 21, 128'h00000001_00000000_00000063_00000062, {6'd1, 6'd0, 6'd63, 6'd62}};
        v[2] = '{6'd5,  7'd1, 3, 0, 4,  18, 128'h00000000_00000000_00000000_DEADBEEF, 24'd5};
        v[3] = '{6'd10, 7'd0, 0, 0, 0,  1,  128'h0, 24'd0};
        v[4] = '{6'd0,  7'd2, 0, 3, 8,  11, 128'h00000000_00000000_00000001_00000000, {6'd1, 6'd0}};
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[0] = 32'h11223344;
        mem[1] = 32'hAABBCCDD;
        mem[2] = 32'h00000001;
        mem[5] = 32'hDEADBEEF;
        mem[62] = 32'h62;
        mem[63] = 32'h63;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_addr", 128'(mem_addr), 128'd0);
        chk("rst_tx_valid", 128'(tx_valid), 128'd0);
        chk("rst_tx_data", 128'(tx_data), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        areset = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                mem[0] = 32'h0;
                mem[1] = 32'h1;
            end
            run_dump(v[i].base, v[i].cnt, v[i].stall, v[i].pulse);
            chk($sformatf("v%0d_nbytes", i), 128'(got.size()), 128'(v[i].nb));
            for (int j = 0; j < got.size() && j < 16; j++)
                chk($sformatf("v%0d_byte%0d", i, j), 128'(got[j]), 128'(v[i].exp[8*j +: 8]));
            for (int w = 0; w < got_addr.size() && w < 4; w++)
                chk($sformatf("v%0d_addr%0d", i, w), 128'(got_addr[w]), 128'(v[i].addrs[6*w +: 6]));
            chk($sformatf("v%0d_done_cycle", i), 128'(done_c), 128'(v[i].done_c));
            chk($sformatf("v%0d_done_pulses", i), 128'(done_n), 128'd1);
            chk($sformatf("v%0d_busy_after", i), 128'(busy_after), 128'd0);
        end

        // Full-memory dump interrupted by reset during byte 2 of word 5 (cycle 29).
        base_addr = 0;
        word_count = 7'd64;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        tx_ready = 1;
        repeat (28) @(posedge clk);
        #1;
        chk("pre_rst_valid", 128'(tx_valid), 128'd1);
        chk("pre_rst_addr", 128'(mem_addr), 128'd5);
        chk("pre_rst_byte", 128'(tx_data), 128'hAD);
        areset = 0;
        #1;
        chk("mid_rst_valid", 128'(tx_valid), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_addr", 128'(mem_addr), 128'd0);
        chk("mid_rst_data", 128'(tx_data), 128'd0);
        #2;
        areset = 1;
        quiet = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tx_valid || busy || done) quiet++;
        end
        chk("post_rst_quiet", 128'(quiet), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_dump_streamer.md
Name: dmem_dump_streamer

Overview:
- Reader counterpart to the bench-side memory preload: walks a window of the MC data memory through a read port and streams its contents out as bytes over a valid/ready interface.
- Lets a bench or debug host pull results out of data memory after a program run, without hierarchical peeking.
- Sits beside MC's data memory and uses only the memory's asynchronous read port.

Parameters:
- DEPTH, 64, number of data-memory words; address arithmetic wraps modulo DEPTH.
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W.
- DATA_W, 32, memory word width; must be a multiple of 8. BYTES = DATA_W/8.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- areset  input  1  asynchronous active-low reset.
- start  input  1  request a dump; sampled only in IDLE.
- base_addr  input  ADDR_W  first word index; latched on an accepted start.
- word_count  input  ADDR_W+1  number of words to dump (0..DEPTH); latched on an accepted start.
- mem_addr  output  ADDR_W  word address to data-memory read port; registered.
- mem_rdata  input  DATA_W  combinational read data for mem_addr.
- tx_data  output  8  current byte.
- tx_valid  output  1  byte valid.
- tx_ready  input  1  downstream accepts the byte when tx_valid && tx_ready.
- busy  output  1  high in FETCH and SEND.
- done  output  1  one-cycle pulse at end of a dump.

Behaviour:
- Reset (areset low, asynchronous): state=IDLE; mem_addr=0, tx_data=0, tx_valid=0, busy=0, done=0; remaining count, byte index and shift register cleared. Takes effect immediately, including mid-dump; tx_valid drops without completing the handshake. No resume after reset.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 and word_count!=0: latch mem_addr<=base_addr and remaining<=word_count; go to FETCH.
  - start=1 and word_count==0: go to DONE; no bytes are emitted.
  - start=0: stay in IDLE.
- FETCH (1 cycle): shift register <= mem_rdata at mem_addr; byte_idx <= 0; go to SEND.
- SEND:
  - tx_valid=1; tx_data = shift[7:0], sent little-endian (byte 0 = bits 7:0 first).
  - tx_data and tx_valid hold stable while tx_ready=0.
  - On handshake with byte_idx < BYTES-1: shift right 8 and increment byte_idx.
  - On handshake with byte_idx == BYTES-1: decrement remaining.
    - If remaining was 1: go to DONE.
    - Otherwise: mem_addr <= mem_addr+1, wrapping DEPTH-1 -> 0, and go to FETCH.
- DONE (1 cycle): done=1, busy=0, tx_valid=0; then IDLE.
- start is ignored outside IDLE. start held high continuously re-triggers a dump each time IDLE is re-entered.
- Latency and throughput:
  - start sampled at edge k -> FETCH in cycle k+1 -> first tx_valid in cycle k+2.
  - With tx_ready held high, each word takes 1+BYTES cycles (5 at defaults).
  - N words complete with done asserted in cycle k+1+N*(1+BYTES).
- word_count=DEPTH dumps the full memory once, starting at base_addr and wrapping around.
- mem_addr holds its last value in IDLE and DONE.

Test Plan:
- Preload mem[0..2]=0x11223344, 0xAABBCCDD, 0x00000001; start with base=0, count=3, tx_ready=1 -> bytes 44 33 22 11 DD CC BB AA 01 00 00 00; done pulses exactly 15 cycles after the FETCH of word 0 begins; busy low afterwards.
- Wrap: mem[62]=0x62, mem[63]=0x63, mem[0]=0x00, mem[1]=0x01 (upper bytes 0); base=62, count=4 -> mem_addr sequence 62, 63, 0, 1; first byte of each word is 62, 63, 00, 01; 16 bytes total.
- Backpressure: count=1, word 0xDEADBEEF, tx_ready low for 3 cycles at each byte -> tx_data stable at EF, then BE, AD, DE across the stalls; no byte duplicated or dropped; done after the 4th handshake.
- Zero count: start with count=0 -> no tx_valid; done high exactly one cycle, two cycles after start; FSM back in IDLE.
- Reset mid-dump: count=64, assert areset low during byte 2 of word 5 -> tx_valid, busy, mem_addr and tx_data are 0 in the same cycle; after release, no bytes appear until a new start.
- start pulsed during SEND of a dump with count=2 -> ignored; exactly 8 bytes and a single done pulse.
